// File: rtl/uart_rx_pkg.sv
// Shared constants, state encoding and frame configuration for the UART receive engine.
package uart_rx_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned CNT_W      = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned DATA_W     = 8;

  localparam logic [CNT_W-1:0] SAMPLE_LO  = CNT_W'(7);
  localparam logic [CNT_W-1:0] SAMPLE_MID = CNT_W'(8);
  localparam logic [CNT_W-1:0] SAMPLE_HI  = CNT_W'(9);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  typedef struct packed {
    logic bit8;
    logic parity_en;
    logic odd_n_even;
  } frame_cfg_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchroniser for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ff <= '1;
    else          ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x-oversampling UART receiver: start detection, mid-bit voting, deframing and a
// single-entry holding register with valid/ready handshake and error flags.
module uart_rx_oversample
  import uart_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAJORITY_EN = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              baud_clock,
  input  logic              rx,
  input  logic              bit8,
  input  logic              parity_en,
  input  logic              odd_n_even,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              framing_err,
  output logic              overflow,
  output logic              busy
);

  logic rx_s;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              perr_q, perr_d;
  logic              s_lo_q, s_lo_d;
  logic              s_mid_q, s_mid_d;
  frame_cfg_t        cfg_q, cfg_d;
  logic              vote_c;
  logic              complete_c;
  logic [IDX_W-1:0]  last_idx_c;
  logic [DATA_W-1:0] frame_data_c;

  // Third sample is the live synchronised line at cnt 9
  assign vote_c       = (MAJORITY_EN != 0) ? majority3(s_lo_q, s_mid_q, rx_s) : s_mid_q;
  assign last_idx_c   = cfg_q.bit8 ? IDX_W'(7) : IDX_W'(6);
  assign frame_data_c = cfg_q.bit8 ? shift_q : {1'b0, shift_q[DATA_W-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      s_lo_q  <= 1'b1;
      s_mid_q <= 1'b1;
      cfg_q   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      s_lo_q  <= s_lo_d;
      s_mid_q <= s_mid_d;
      cfg_q   <= cfg_d;
      busy    <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    perr_d     = perr_q;
    s_lo_d     = s_lo_q;
    s_mid_d    = s_mid_q;
    cfg_d      = cfg_q;
    complete_c = 1'b0;
    if (baud_clock) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == SAMPLE_LO)  s_lo_d  = rx_s;
      if (cnt_q == SAMPLE_MID) s_mid_d = rx_s;
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_START;
            idx_d   = '0;
            par_d   = 1'b0;
            perr_d  = 1'b0;
            cfg_d   = '{bit8: bit8, parity_en: parity_en, odd_n_even: odd_n_even};
          end
        end
        ST_START: begin
          if (cnt_q == SAMPLE_HI && vote_c) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == LAST_CNT) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end
        end
        ST_DATA: begin
          if (cnt_q == SAMPLE_HI) begin
            shift_d = {vote_c, shift_q[DATA_W-1:1]};
            par_d   = par_q ^ vote_c;
          end
          if (cnt_q == LAST_CNT) begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == last_idx_c) state_d = cfg_q.parity_en ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (cnt_q == SAMPLE_HI) perr_d = ((par_q ^ vote_c) != cfg_q.odd_n_even);
          if (cnt_q == LAST_CNT)  state_d = ST_STOP;
        end
        ST_STOP: begin
          // Return to IDLE at mid-stop so a back-to-back start edge is not missed
          if (cnt_q == SAMPLE_HI) begin
            complete_c = 1'b1;
            state_d    = ST_IDLE;
            cnt_d      = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Holding register: a completion while full and not being drained is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (complete_c) begin
        if (!rx_valid || rx_ready) begin
          rx_data     <= frame_data_c;
          rx_valid    <= 1'b1;
          parity_err  <= cfg_q.parity_en & perr_q;
          framing_err <= ~vote_c;
        end else begin
          overflow <= 1'b1;
        end
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: baud tick every 4 clk, one bit cell = 64 clk.
module tb_uart_rx_oversample;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       baud_clock = 1'b0;
  logic       rx;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;
  logic       busy;

  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         ovf_cnt = 0;
  int         ovf_base;
  logic [1:0] bph = 2'd0;

  uart_rx_oversample #(.SYNC_STAGES(2), .MAJORITY_EN(1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .baud_clock  (baud_clock),
    .rx          (rx),
    .bit8        (bit8),
    .parity_en   (parity_en),
    .odd_n_even  (odd_n_even),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bph <= bph + 2'd1;

  initial forever begin
    @(negedge clk);
    baud_clock = (bph == 2'd0);
  end

  always @(negedge clk) if (overflow) ovf_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Ends on the negedge that raises baud_clock, so frame timing is deterministic
  task automatic align();
    do @(negedge clk); while (bph != 2'd0);
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    rx = b;
    if (glitch) begin
      idle_clks(36);
      rx = ~b;
      idle_clks(4);
      rx = b;
      idle_clks(24);
    end else begin
      idle_clks(64);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop_b,
                            input int glitch_idx);
    int n;
    n = bit8 ? 8 : 7;
    align();
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < n; i++) drive_bit(d[i], i == glitch_idx);
    if (parity_en) drive_bit(pbit, 1'b0);
    drive_bit(stop_b, 1'b0);
    rx = 1'b1;
  endtask

  task automatic ready_pulse();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic b8, input logic pe, input logic odd);
    bit8       = b8;
    parity_en  = pe;
    odd_n_even = odd;
  endtask

  initial begin
    reset_n  = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    set_cfg(1'b1, 1'b0, 1'b0);
    idle_clks(3);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset flags", 32'({parity_err, framing_err}), 32'd0);
    reset_n = 1'b1;
    idle_clks(20);

    // 8N1 0xA5 held until consumed
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    idle_clks(32);
    check("8n1 valid", 32'(rx_valid), 32'd1);
    check("8n1 data", 32'(rx_data), 32'hA5);
    check("8n1 flags", 32'({parity_err, framing_err}), 32'd0);
    check("8n1 busy", 32'(busy), 32'd0);
    idle_clks(40);
    check("8n1 still held", 32'(rx_valid), 32'd1);
    ready_pulse();
    check("8n1 consumed", 32'(rx_valid), 32'd0);

    // 7E1 0x41 (two ones) with parity bit 1 -> parity error
    set_cfg(1'b0, 1'b1, 1'b0);
    send_frame(8'h41, 1'b1, 1'b1, -1);
    idle_clks(32);
    check("7e1 data", 32'(rx_data), 32'h41);
    check("7e1 parity_err", 32'(parity_err), 32'd1);
    check("7e1 framing_err", 32'(framing_err), 32'd0);
    ready_pulse();

    // 7O1 0x41 with parity bit 1 -> correct parity
    set_cfg(1'b0, 1'b1, 1'b1);
    send_frame(8'h41, 1'b1, 1'b1, -1);
    idle_clks(32);
    check("7o1 valid", 32'(rx_valid), 32'd1);
    check("7o1 data", 32'(rx_data), 32'h41);
    check("7o1 parity_err", 32'(parity_err), 32'd0);
    ready_pulse();

    // 8O1 0xA5 (four ones) with parity bit 0 -> parity error
    set_cfg(1'b1, 1'b1, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    idle_clks(32);
    check("8o1 data", 32'(rx_data), 32'hA5);
    check("8o1 parity_err", 32'(parity_err), 32'd1);
    ready_pulse();

    // Stop bit low -> framing error, then a clean frame
    set_cfg(1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    idle_clks(128);
    check("ferr valid", 32'(rx_valid), 32'd1);
    check("ferr data", 32'(rx_data), 32'h3C);
    check("ferr framing_err", 32'(framing_err), 32'd1);
    check("ferr idle after", 32'(busy), 32'd0);
    ready_pulse();
    send_frame(8'hC3, 1'b0, 1'b1, -1);
    idle_clks(32);
    check("post ferr data", 32'(rx_data), 32'hC3);
    check("post ferr framing_err", 32'(framing_err), 32'd0);
    ready_pulse();

    // Start glitch of 3 ticks is rejected
    align();
    rx = 1'b0;
    idle_clks(12);
    rx = 1'b1;
    idle_clks(8);
    check("glitch busy rises", 32'(busy), 32'd1);
    idle_clks(80);
    check("glitch busy falls", 32'(busy), 32'd0);
    check("glitch no valid", 32'(rx_valid), 32'd0);

    // Overflow: second frame dropped while the first is held
    ovf_base = ovf_cnt;
    send_frame(8'h11, 1'b0, 1'b1, -1);
    send_frame(8'h22, 1'b0, 1'b1, -1);
    idle_clks(32);
    check("ovf data kept", 32'(rx_data), 32'h11);
    check("ovf valid", 32'(rx_valid), 32'd1);
    check("ovf pulses", 32'(ovf_cnt - ovf_base), 32'd1);
    ready_pulse();

    // Drain on the completion clock: new frame loads, no overflow
    ovf_base = ovf_cnt;
    send_frame(8'h11, 1'b0, 1'b1, -1);
    fork
      send_frame(8'h22, 1'b0, 1'b1, -1);
      begin
        align();
        idle_clks(620);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    idle_clks(16);
    check("swap data", 32'(rx_data), 32'h22);
    check("swap valid", 32'(rx_valid), 32'd1);
    check("swap no ovf", 32'(ovf_cnt - ovf_base), 32'd0);
    ready_pulse();

    // One-sample glitch at cnt 8 on data bit 3 is outvoted
    send_frame(8'h00, 1'b0, 1'b1, 3);
    idle_clks(32);
    check("vote data", 32'(rx_data), 32'h00);
    check("vote valid", 32'(rx_valid), 32'd1);

    // Asynchronous reset in the middle of a data bit, with a frame still held
    align();
    rx = 1'b0;
    idle_clks(64);
    rx = 1'b1;
    idle_clks(64);
    rx = 1'b0;
    idle_clks(32);
    check("pre-reset busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid reset valid", 32'(rx_valid), 32'd0);
    check("mid reset data", 32'(rx_data), 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    rx = 1'b1;
    idle_clks(4);
    reset_n = 1'b1;
    idle_clks(128);
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    idle_clks(32);
    check("post reset data", 32'(rx_data), 32'h5A);
    check("post reset valid", 32'(rx_valid), 32'd1);
    check("post reset flags", 32'({parity_err, framing_err}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
